// File: rtl/score_display_pkg.sv
// Shared types for the score display path: 7-segment encodings (active-low,
// DE1-SoC HEX wiring), the blank pattern, the BCD-to-segment helper and the
// converter FSM states.
package score_display_pkg;

  typedef enum logic [6:0] {
    ZERO  = 7'b1000000,
    ONE   = 7'b1111001,
    TWO   = 7'b0100100,
    THREE = 7'b0110000,
    FOUR  = 7'b0011001,
    FIVE  = 7'b0010010,
    SIX   = 7'b0000010,
    SEVEN = 7'b1111000,
    EIGHT = 7'b0000000,
    NINE  = 7'b0010000,
    BLANK = 7'b1111111
  } Seg7Disp;

  localparam Seg7Disp SEG7_BLANK = BLANK;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_e;

  // Map one BCD nibble to its segment pattern; out-of-range nibbles go dark.
  function automatic Seg7Disp bcd_to_seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    return ZERO;
      4'd1:    return ONE;
      4'd2:    return TWO;
      4'd3:    return THREE;
      4'd4:    return FOUR;
      4'd5:    return FIVE;
      4'd6:    return SIX;
      4'd7:    return SEVEN;
      4'd8:    return EIGHT;
      4'd9:    return NINE;
      default: return SEG7_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3). One bit is consumed per
// clock; a conversion takes SCORE_W shift edges after the start edge.
// valid is high in the cycle whose closing edge applies the final shift, so
// bcd holds the finished result from the following cycle until the next start.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int unsigned SCORE_W    = 20,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    valid
);

  localparam int unsigned CNT_W = $clog2(SCORE_W + 1);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  logic [SCORE_W-1:0] shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift {bcd, shift} left once per edge for SCORE_W edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[SCORE_W-1]};
      shift_q <= {shift_q[SCORE_W-2:0], 1'b0};
      cnt_q   <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(SCORE_W - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign valid = run_q && (cnt_q == CNT_W'(SCORE_W - 1));
  assign bcd   = bcd_q;

endmodule

// File: rtl/score_display.sv
// Score to HEX display driver: saturates the binary score, converts it to BCD
// through bin2bcd_seq, encodes each digit to 7-segment and registers the
// result. hex only changes on reset or at the end of a conversion.
// Optional leading-zero blanking is enabled by defining SCORE_DISPLAY_LZB_EN.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned SCORE_W    = 20,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SCORE_W-1:0]             score_i,
  input  logic                           load,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_DIGITS-1:0][6:0]     hex
);

  localparam int unsigned MAX_SCORE = (10 ** NUM_DIGITS) - 1;

  state_e                    state_q;
  logic                      start;
  logic [SCORE_W-1:0]        score_sat;
  logic [4*NUM_DIGITS-1:0]   bcd;
  logic                      cvt_valid;
  logic [NUM_DIGITS-1:0][6:0] seg_next;
  logic [3:0]                nib;
`ifdef SCORE_DISPLAY_LZB_EN
  logic                      lead;
`endif

  // Loads are only accepted while idle; anything else is dropped.
  always_comb begin
    start     = (state_q == IDLE) && load;
    score_sat = (32'(score_i) > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : score_i;
  end

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (score_sat),
    .bcd   (bcd),
    .valid (cvt_valid)
  );

  // Per-digit segment patterns, scanning from the top digit for blanking.
  always_comb begin
    seg_next = '1;
    nib      = '0;
`ifdef SCORE_DISPLAY_LZB_EN
    lead     = 1'b1;
`endif
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib         = bcd[4*i +: 4];
      seg_next[i] = bcd_to_seg7(nib);
`ifdef SCORE_DISPLAY_LZB_EN
      // Digit 0 always shows so a zero score reads as a single 0.
      if (lead && (nib == 4'd0) && (i != 0)) begin
        seg_next[i] = SEG7_BLANK;
      end else begin
        lead = 1'b0;
      end
`endif
    end
  end

  // Control FSM with registered busy/done/hex.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hex     <= '1;  // all digits SEG7_BLANK
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cvt_valid) begin
            state_q <= ENCODE;
          end
        end
        ENCODE: begin
          hex     <= seg_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
